// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_pkg
//  Description : Shared types and helpers for the UART transmit engine.
//                - tx_state_t : frame sequencer states
//                - PAR_EVEN / PAR_ODD : parity sense encodings
//                - frame_bits() : serial bits per frame for a configuration
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Start bit + data bits + optional parity + one or two stop bits.
    function automatic int unsigned frame_bits(input int unsigned dw,
                                               input logic        par_en,
                                               input logic        stop_two);
        return 32'd2 + dw + 32'(par_en) + 32'(stop_two);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_frame_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bit_timer
//  Description : Bit-period counter. Counts 0..limit while running and flags
//                o_bit_end on the last cycle of each bit period. i_restart
//                captures a new limit and clears the count, so a new frame
//                always starts on a clean bit boundary.
//  Ports       : CLK        - clock, posedge
//                RST        - asynchronous active-low reset
//                i_restart  - capture i_prescale, clear count
//                i_run      - count enable (frame in progress)
//                i_prescale - cycles per bit minus 1
//                o_bit_end  - last cycle of the current bit period
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      i_restart,
    input  logic                      i_run,
    input  logic [PRESCALE_WIDTH-1:0] i_prescale,
    output logic                      o_bit_end
);

    logic [PRESCALE_WIDTH-1:0] r_limit;
    logic [PRESCALE_WIDTH-1:0] r_count;

    assign o_bit_end = i_run && (r_count == r_limit);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_limit <= '0;
            r_count <= '0;
        end else if (i_restart) begin
            r_limit <= i_prescale;
            r_count <= '0;
        end else if (i_run) begin
            if (o_bit_end) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_frame
//  Description : Parametrised UART transmitter. Words enter a one-entry
//                holding buffer through a valid/ready handshake and are sent
//                as start, LSB-first data, optional parity, one or two stop
//                bits. A buffered word is loaded on the final stop bit so
//                consecutive frames leave no idle gap.
//  Ports       : CLK          - clock, posedge
//                RST          - asynchronous active-low reset
//                Cfg_Prescale - cycles per bit minus 1 (latched per frame)
//                Cfg_Par_En   - insert parity bit (latched per frame)
//                Cfg_Par_Odd  - 0 even / 1 odd parity (latched per frame)
//                Cfg_Stop_Two - two stop bits (latched per frame)
//                Data_Valid   - upstream word valid
//                Data_In      - upstream word
//                Data_Ready   - holding buffer empty
//                TX_Out       - registered serial line, idle high
//                Busy         - frame in progress or buffer full
//                Done_Pulse   - high during the last cycle of the final stop bit
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [PRESCALE_WIDTH-1:0] Cfg_Prescale,
    input  logic                      Cfg_Par_En,
    input  logic                      Cfg_Par_Odd,
    input  logic                      Cfg_Stop_Two,
    input  logic                      Data_Valid,
    input  logic [DATA_WIDTH-1:0]     Data_In,
    output logic                      Data_Ready,
    output logic                      TX_Out,
    output logic                      Busy,
    output logic                      Done_Pulse
);

    localparam int                c_IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_WIDTH - 1);

    tx_state_t             r_state;
    tx_state_t             w_next_state;

    logic [DATA_WIDTH-1:0] r_buf;
    logic                  r_buf_full;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic [c_IDX_W-1:0]    r_data_idx;
    logic                  r_stop_idx;
    logic                  r_par_en;
    logic                  r_stop_two;
    logic                  r_par_bit;
    logic                  r_tx;

    logic                  w_accept;
    logic                  w_load;
    logic                  w_shift_en;
    logic                  w_bit_end;
    logic                  w_last_stop;
    logic                  w_done;
    logic                  w_tx_next;

    // Accept only into an empty buffer; a load needs a full one, so the two
    // never coincide and the buffer needs no bypass path.
    assign w_accept = Data_Valid && !r_buf_full;

    uart_bit_timer #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_bit_timer (
        .CLK        (CLK),
        .RST        (RST),
        .i_restart  (w_load),
        .i_run      (r_state != IDLE),
        .i_prescale (Cfg_Prescale),
        .o_bit_end  (w_bit_end)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_shift_en   = 1'b0;
        w_done       = 1'b0;
        w_last_stop  = r_stop_two ? r_stop_idx : 1'b1;

        case (r_state)
            IDLE: begin
                if (r_buf_full) begin
                    w_load       = 1'b1;
                    w_next_state = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_next_state = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_shift_en = 1'b1;
                    if (r_data_idx == c_LAST_IDX) begin
                        w_next_state = r_par_en ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_next_state = STOP;
                end
            end
            STOP: begin
                if (w_bit_end && w_last_stop) begin
                    w_done = 1'b1;
                    // Chain straight into the next start bit when a word waits.
                    if (r_buf_full) begin
                        w_load       = 1'b1;
                        w_next_state = START;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        if (w_load) begin
            w_shift_next = r_buf;
        end else if (w_shift_en) begin
            w_shift_next = r_shift >> 1;
        end else begin
            w_shift_next = r_shift;
        end

        // Line level follows the state being entered so TX_Out is a plain flop.
        case (w_next_state)
            IDLE:    w_tx_next = 1'b1;
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            PARITY:  w_tx_next = r_par_bit;
            STOP:    w_tx_next = 1'b1;
            default: w_tx_next = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_shift    <= '0;
            r_data_idx <= '0;
            r_stop_idx <= 1'b0;
            r_par_en   <= 1'b0;
            r_stop_two <= 1'b0;
            r_par_bit  <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_tx    <= w_tx_next;
            r_shift <= w_shift_next;

            if (w_accept) begin
                r_buf      <= Data_In;
                r_buf_full <= 1'b1;
            end else if (w_load) begin
                r_buf_full <= 1'b0;
            end

            if (w_load) begin
                r_par_en   <= Cfg_Par_En;
                r_stop_two <= Cfg_Stop_Two;
                // Parity comes from the whole word now, before shifting
                // destroys it.
                r_par_bit  <= (^r_buf) ^ (Cfg_Par_Odd == PAR_ODD);
                r_data_idx <= '0;
                r_stop_idx <= 1'b0;
            end else begin
                if (w_shift_en) begin
                    r_data_idx <= r_data_idx + c_IDX_W'(1);
                end
                if ((r_state == STOP) && w_bit_end) begin
                    r_stop_idx <= 1'b1;
                end
            end
        end
    end

    assign TX_Out     = r_tx;
    assign Data_Ready = !r_buf_full;
    assign Busy       = (r_state != IDLE) || r_buf_full;
    assign Done_Pulse = w_done;

endmodule
`default_nettype wire
